// File: rtl/my_err_gen_pkg.sv
// rtl/my_err_gen_pkg.sv - shared state encoding, default widths and error saturation helper
package my_err_gen_pkg;

    localparam int ADC_BIT_DEF     = 14;
    localparam int ERR_W_DEF       = 32;
    localparam int AVG_SEL_MAX_DEF = 12;
    // Accumulator width for the default configuration; the top derives its own from its parameters.
    localparam int ACC_W           = ADC_BIT_DEF + AVG_SEL_MAX_DEF;
    // Widest ERR_W the saturation helper supports.
    localparam int SAT_MAX_W       = 64;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WAIT_TRIG = 4'd1,
        SETTLE    = 4'd2,
        ACQ       = 4'd3,
        AVG       = 4'd4,
        ERR_GEN   = 4'd5,
        SYNC_DLY  = 4'd6,
        RATE      = 4'd7,
        RAMP      = 4'd8,
        WAIT_NEXT = 4'd9
    } state_t;

    // Clamp an (err_w+1)-bit difference, sign-extended to SAT_MAX_W+1 bits, into the
    // signed err_w range. The caller truncates the result back to err_w bits.
    function automatic logic signed [SAT_MAX_W-1:0] sat_err(
        input logic signed [SAT_MAX_W:0] diff,
        input int unsigned               err_w
    );
        logic signed [SAT_MAX_W:0] one;
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        one    = '0;
        one[0] = 1'b1;
        hi     = (one <<< (err_w - 1)) - one;
        lo     = -hi - one;
        if (diff > hi) begin
            sat_err = hi[SAT_MAX_W-1:0];
        end else if (diff < lo) begin
            sat_err = lo[SAT_MAX_W-1:0];
        end else begin
            sat_err = diff[SAT_MAX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/my_half_avg.sv
// rtl/my_half_avg.sv - accumulates 2^sel samples of one modulation half and shifts down to the mean
// Ports: i_start loads the clamped sel and clears the sum; i_abort discards everything;
//        o_done is high during the last accumulated sample; o_avg = sum >>> sel (valid after done).
module my_half_avg
    import my_err_gen_pkg::*;
#(
    parameter int ADC_BIT     = ADC_BIT_DEF,
    parameter int AVG_SEL_MAX = AVG_SEL_MAX_DEF,
    parameter int ACC_WIDTH   = ADC_BIT + AVG_SEL_MAX
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic [4:0]                  i_sel,
    input  logic signed [ADC_BIT-1:0]   i_data,
    output logic                        o_done,
    output logic signed [ACC_WIDTH-1:0] o_avg
);

    localparam int         CNT_W   = AVG_SEL_MAX + 1;
    localparam logic [4:0] SEL_MAX = 5'(AVG_SEL_MAX);

    logic                        busy_q, busy_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [4:0]                  sel_q, sel_d;
    logic [4:0]                  sel_clamped;
    logic [CNT_W-1:0]            last_idx;

    assign sel_clamped = (i_sel > SEL_MAX) ? SEL_MAX : i_sel;
    assign last_idx    = (CNT_W'(1) << sel_q) - CNT_W'(1);
    assign o_done      = busy_q && (cnt_q == last_idx);
    assign o_avg       = acc_q >>> sel_q;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        sel_d  = sel_q;
        if (i_abort) begin
            busy_d = 1'b0;
            cnt_d  = '0;
            acc_d  = '0;
        end else if (i_start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            acc_d  = '0;
            sel_d  = sel_clamped;
        end else if (busy_q) begin
            acc_d = acc_q + ACC_WIDTH'(i_data);
            if (cnt_q == last_idx) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            sel_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            sel_q  <= sel_d;
        end
    end

endmodule

// File: rtl/my_err_signal_gen_v3.sv
// rtl/my_err_signal_gen_v3.sv - square-wave demodulating error generator with sync pulse train
// Ports: i_trig/i_status mark each modulation edge and its level; i_adc_data is averaged per half;
//        o_err = saturated (high+offset)-low (or reversed by i_polarity); o_*_sync form the
//        4-cycle integrator pulse train; o_overrun/o_timeout flag early triggers and a stalled loop.
module my_err_signal_gen_v3
    import my_err_gen_pkg::*;
#(
    parameter int ADC_BIT     = ADC_BIT_DEF,
    parameter int ERR_W       = ERR_W_DEF,
    parameter int AVG_SEL_MAX = AVG_SEL_MAX_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_status,
    input  logic                      i_trig,
    input  logic                      i_polarity,
    input  logic [31:0]               i_wait_cnt,
    input  logic [4:0]                i_avg_sel,
    input  logic [31:0]               i_timeout_cnt,
    input  logic signed [ERR_W-1:0]   i_err_offset,
    input  logic signed [ADC_BIT-1:0] i_adc_data,
    output logic signed [ERR_W-1:0]   o_err,
    output logic                      o_step_sync,
    output logic                      o_step_sync_dly,
    output logic                      o_rate_sync,
    output logic                      o_ramp_sync,
    output logic                      o_overrun,
    output logic                      o_timeout,
    output logic signed [ERR_W-1:0]   o_low_avg,
    output logic signed [ERR_W-1:0]   o_high_avg,
    output logic [3:0]                o_cstate
);

    localparam int ACC_WIDTH = ADC_BIT + AVG_SEL_MAX;

    state_t                    state_q, state_d;
    logic                      phase_q, phase_d;
    logic                      low_valid_q, low_valid_d;
    logic [31:0]               settle_q, settle_d;
    logic [31:0]               wd_q, wd_d;
    logic signed [ERR_W-1:0]   err_q, err_d;
    logic signed [ERR_W-1:0]   low_avg_q, low_avg_d;
    logic signed [ERR_W-1:0]   high_avg_q, high_avg_d;
    logic                      step_q, step_d;
    logic                      step_dly_q, step_dly_d;
    logic                      rate_q, rate_d;
    logic                      ramp_q, ramp_d;
    logic                      overrun_q, overrun_d;
    logic                      timeout_q, timeout_d;

    logic                      avg_start;
    logic                      avg_abort;
    logic                      half_done;
    logic signed [ACC_WIDTH-1:0] half_avg;
    logic signed [ERR_W-1:0]   avg_ext;
    logic signed [ERR_W:0]     diff;
    logic signed [ERR_W-1:0]   err_sat;

    my_half_avg #(
        .ADC_BIT     (ADC_BIT),
        .AVG_SEL_MAX (AVG_SEL_MAX),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_half_avg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (avg_start),
        .i_abort (avg_abort),
        .i_sel   (i_avg_sel),
        .i_data  (i_adc_data),
        .o_done  (half_done),
        .o_avg   (half_avg)
    );

    // The shifted mean always fits in ADC_BIT signed bits, so resizing to ERR_W is lossless.
    assign avg_ext = ERR_W'(half_avg);
    // One extra bit keeps the subtraction exact before clamping.
    assign diff    = i_polarity ? ((ERR_W+1)'(low_avg_q) - (ERR_W+1)'(high_avg_q))
                                : ((ERR_W+1)'(high_avg_q) - (ERR_W+1)'(low_avg_q));
    assign err_sat = ERR_W'(sat_err((SAT_MAX_W+1)'(diff), ERR_W));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        low_valid_d = low_valid_q;
        settle_d    = settle_q;
        wd_d        = '0;
        err_d       = err_q;
        low_avg_d   = low_avg_q;
        high_avg_d  = high_avg_q;
        step_d      = 1'b0;
        step_dly_d  = 1'b0;
        rate_d      = 1'b0;
        ramp_d      = 1'b0;
        overrun_d   = 1'b0;
        timeout_d   = 1'b0;
        avg_start   = 1'b0;
        avg_abort   = 1'b0;

        if (!i_en) begin
            state_d     = IDLE;
            low_valid_d = 1'b0;
            avg_abort   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_TRIG;
                end
                WAIT_TRIG: begin
                    if (i_trig) begin
                        phase_d  = i_status;
                        settle_d = i_wait_cnt;
                        state_d  = SETTLE;
                    end else if ((i_timeout_cnt != 32'd0) && (wd_q + 32'd1 == i_timeout_cnt)) begin
                        timeout_d   = 1'b1;
                        low_valid_d = 1'b0;
                    end else begin
                        wd_d = wd_q + 32'd1;
                    end
                end
                SETTLE, ACQ: begin
                    if (i_trig) begin
                        // Early edge: drop the partial half and restart on the new one.
                        overrun_d   = 1'b1;
                        avg_abort   = 1'b1;
                        low_valid_d = 1'b0;
                        phase_d     = i_status;
                        settle_d    = i_wait_cnt;
                        state_d     = SETTLE;
                    end else if (state_q == SETTLE) begin
                        if (settle_q == 32'd0) begin
                            avg_start = 1'b1;
                            state_d   = ACQ;
                        end else begin
                            settle_d = settle_q - 32'd1;
                        end
                    end else if (half_done) begin
                        state_d = AVG;
                    end
                end
                AVG: begin
                    if (!phase_q) begin
                        low_avg_d   = avg_ext;
                        low_valid_d = 1'b1;
                        state_d     = WAIT_TRIG;
                    end else if (low_valid_q) begin
                        high_avg_d = avg_ext + i_err_offset;
                        state_d    = ERR_GEN;
                    end else begin
                        state_d = WAIT_TRIG;
                    end
                end
                ERR_GEN: begin
                    err_d       = err_sat;
                    step_d      = 1'b1;
                    low_valid_d = 1'b0;
                    state_d     = SYNC_DLY;
                end
                SYNC_DLY: begin
                    step_dly_d = 1'b1;
                    state_d    = RATE;
                end
                RATE: begin
                    rate_d  = 1'b1;
                    state_d = RAMP;
                end
                RAMP: begin
                    ramp_d  = 1'b1;
                    state_d = WAIT_NEXT;
                end
                WAIT_NEXT: begin
                    state_d = WAIT_TRIG;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            low_valid_q <= 1'b0;
            settle_q    <= '0;
            wd_q        <= '0;
            err_q       <= '0;
            low_avg_q   <= '0;
            high_avg_q  <= '0;
            step_q      <= 1'b0;
            step_dly_q  <= 1'b0;
            rate_q      <= 1'b0;
            ramp_q      <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            low_valid_q <= low_valid_d;
            settle_q    <= settle_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            low_avg_q   <= low_avg_d;
            high_avg_q  <= high_avg_d;
            step_q      <= step_d;
            step_dly_q  <= step_dly_d;
            rate_q      <= rate_d;
            ramp_q      <= ramp_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_err           = err_q;
    assign o_step_sync     = step_q;
    assign o_step_sync_dly = step_dly_q;
    assign o_rate_sync     = rate_q;
    assign o_ramp_sync     = ramp_q;
    assign o_overrun       = overrun_q;
    assign o_timeout       = timeout_q;
    assign o_low_avg       = low_avg_q;
    assign o_high_avg      = high_avg_q;
    assign o_cstate        = state_q;

endmodule

// File: tb/tb_my_err_signal_gen_v3.sv
// tb/tb_my_err_signal_gen_v3.sv - randomized self-checking bench for my_err_signal_gen_v3
module tb_my_err_signal_gen_v3;

    localparam int ADC_BIT     = 14;
    localparam int ERR_W       = 16;
    localparam int AVG_SEL_MAX = 4;

    logic                      i_clk = 1'b0;
    logic                      i_rst;
    logic                      i_en;
    logic                      i_status;
    logic                      i_trig;
    logic                      i_polarity;
    logic [31:0]               i_wait_cnt;
    logic [4:0]                i_avg_sel;
    logic [31:0]               i_timeout_cnt;
    logic signed [ERR_W-1:0]   i_err_offset;
    logic signed [ADC_BIT-1:0] i_adc_data;
    logic signed [ERR_W-1:0]   o_err;
    logic                      o_step_sync, o_step_sync_dly, o_rate_sync, o_ramp_sync;
    logic                      o_overrun, o_timeout;
    logic signed [ERR_W-1:0]   o_low_avg, o_high_avg;
    logic [3:0]                o_cstate;

    my_err_signal_gen_v3 #(
        .ADC_BIT     (ADC_BIT),
        .ERR_W       (ERR_W),
        .AVG_SEL_MAX (AVG_SEL_MAX)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_en            (i_en),
        .i_status        (i_status),
        .i_trig          (i_trig),
        .i_polarity      (i_polarity),
        .i_wait_cnt      (i_wait_cnt),
        .i_avg_sel       (i_avg_sel),
        .i_timeout_cnt   (i_timeout_cnt),
        .i_err_offset    (i_err_offset),
        .i_adc_data      (i_adc_data),
        .o_err           (o_err),
        .o_step_sync     (o_step_sync),
        .o_step_sync_dly (o_step_sync_dly),
        .o_rate_sync     (o_rate_sync),
        .o_ramp_sync     (o_ramp_sync),
        .o_overrun       (o_overrun),
        .o_timeout       (o_timeout),
        .o_low_avg       (o_low_avg),
        .o_high_avg      (o_high_avg),
        .o_cstate        (o_cstate)
    );

    always #5 i_clk = ~i_clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int ov_cnt       = 0;
    int step_cnt     = 0;

    always @(negedge i_clk) begin
        if (o_overrun === 1'b1) ov_cnt++;
        if (o_step_sync === 1'b1) step_cnt++;
    end

    // ---------------- reference model ----------------
    function automatic int samples_for(input int sel);
        return 1 << ((sel > AVG_SEL_MAX) ? AVG_SEL_MAX : sel);
    endfunction

    function automatic longint floor_div(input longint a, input longint n);
        longint q = a / n;
        if ((a % n != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint wrap_err(input longint x);
        longint span = longint'(1) << ERR_W;
        longint m    = x % span;
        if (m < 0) m = m + span;
        if (m >= span / 2) m = m - span;
        return m;
    endfunction

    function automatic longint clamp_err(input longint x);
        longint hi = (longint'(1) << (ERR_W - 1)) - 1;
        longint lo = -(longint'(1) << (ERR_W - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic int rand_sample();
        return int'($urandom_range(0, (1 << ADC_BIT) - 1)) - (1 << (ADC_BIT - 1));
    endfunction

    // ---------------- stimulus helpers ----------------
    // Fires a trigger at the current negedge, waits out settling, then drives cnt samples.
    task automatic drive_half(input bit status, input int w, input int cnt, input int smp[16]);
        i_status   = status;
        i_trig     = 1'b1;
        i_wait_cnt = 32'(w);
        for (int i = 0; i < w + 1; i++) begin
            @(negedge i_clk);
            i_trig     = 1'b0;
            i_status   = 1'($urandom_range(0, 1));
            i_adc_data = ADC_BIT'($urandom);
        end
        for (int k = 0; k < cnt; k++) begin
            @(negedge i_clk);
            i_adc_data = ADC_BIT'(smp[k]);
        end
    endtask

    task automatic observe_low(input longint exp_low, input string name);
        @(negedge i_clk);
        @(negedge i_clk);
        tests_run++;
        if (o_low_avg !== ERR_W'(exp_low)) begin
            tests_failed++;
            $display("FAIL %s low_avg: got %0d expected %0d", name, o_low_avg, exp_low);
        end
        tests_run++;
        if (o_cstate !== 4'd1) begin
            tests_failed++;
            $display("FAIL %s low_state: got %0d expected 1", name, o_cstate);
        end
    endtask

    // Pulses are expected on the 3rd..6th negedges after the last high sample.
    task automatic observe_sync(input bit fire, input longint exp_err, input longint exp_high,
                                input string name);
        logic [7:0] m_step, m_dly, m_rate, m_ramp;
        logic [31:0] exp_masks;
        m_step = '0; m_dly = '0; m_rate = '0; m_ramp = '0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge i_clk);
            i_adc_data = ADC_BIT'($urandom);
            m_step[i] = o_step_sync;
            m_dly[i]  = o_step_sync_dly;
            m_rate[i] = o_rate_sync;
            m_ramp[i] = o_ramp_sync;
            if (fire && i == 3) begin
                tests_run++;
                if (o_err !== ERR_W'(exp_err)) begin
                    tests_failed++;
                    $display("FAIL %s err: got %0d expected %0d", name, o_err, exp_err);
                end
                tests_run++;
                if (o_high_avg !== ERR_W'(exp_high)) begin
                    tests_failed++;
                    $display("FAIL %s high_avg: got %0d expected %0d", name, o_high_avg, exp_high);
                end
            end
        end
        exp_masks = fire ? 32'h08_10_20_40 : 32'h0;
        tests_run++;
        if ({m_step, m_dly, m_rate, m_ramp} !== exp_masks) begin
            tests_failed++;
            $display("FAIL %s sync_pulses: got %h expected %h", name,
                     {m_step, m_dly, m_rate, m_ramp}, exp_masks);
        end
        tests_run++;
        if (o_cstate !== 4'd1) begin
            tests_failed++;
            $display("FAIL %s end_state: got %0d expected 1", name, o_cstate);
        end
    endtask

    task automatic run_pair(input int sel, input int w, input bit pol, input longint off,
                            input int lows[16], input int highs[16], input string name,
                            output longint err);
        int n;
        longint sl, sh, low_avg, high_avg, d;
        n  = samples_for(sel);
        sl = 0;
        sh = 0;
        for (int k = 0; k < n; k++) begin
            sl += lows[k];
            sh += highs[k];
        end
        low_avg  = floor_div(sl, n);
        high_avg = wrap_err(floor_div(sh, n) + off);
        d        = pol ? (low_avg - high_avg) : (high_avg - low_avg);
        err      = clamp_err(d);
        i_avg_sel    = 5'(sel);
        i_polarity   = pol;
        i_err_offset = ERR_W'(off);
        drive_half(1'b0, w, n, lows);
        observe_low(low_avg, name);
        drive_half(1'b1, w, n, highs);
        observe_sync(1'b1, err, high_avg, name);
    endtask

    task automatic restart();
        i_en = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_en = 1'b1;
        @(negedge i_clk);
        tests_run++;
        if (o_cstate !== 4'd1) begin
            tests_failed++;
            $display("FAIL restart_state: got %0d expected 1", o_cstate);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst = 1'b1; i_en = 1'b0; i_status = 1'b0; i_trig = 1'b0; i_polarity = 1'b0;
        i_wait_cnt = '0; i_avg_sel = '0; i_timeout_cnt = '0; i_err_offset = '0; i_adc_data = '0;
        repeat (3) @(negedge i_clk);
        tests_run++;
        if (o_cstate !== 4'd0 || o_err !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: state %0d err %0d expected 0 0", o_cstate, o_err);
        end
        tests_run++;
        if ({o_low_avg, o_high_avg} !== '0 ||
            {o_step_sync, o_step_sync_dly, o_rate_sync, o_ramp_sync, o_overrun, o_timeout} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: low %0d high %0d expected all zero", o_low_avg, o_high_avg);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_basic();
        int lows[16], highs[16];
        longint err;
        for (int k = 0; k < 16; k++) begin lows[k] = -100; highs[k] = 300; end
        restart();
        run_pair(2, 3, 1'b0, 0, lows, highs, "basic", err);
        run_pair(2, 3, 1'b1, 50, lows, highs, "offset_polarity", err);
    endtask

    task automatic test_saturation();
        int lows[16], highs[16];
        longint err;
        for (int k = 0; k < 16; k++) begin lows[k] = -8192; highs[k] = 0; end
        run_pair(1, 0, 1'b0, 32767, lows, highs, "sat_pos", err);
        run_pair(1, 0, 1'b1, 32767, lows, highs, "sat_neg", err);
    endtask

    task automatic test_random();
        int lows[16], highs[16];
        longint err;
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 16; k++) begin lows[k] = rand_sample(); highs[k] = rand_sample(); end
            run_pair(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                     1'($urandom_range(0, 1)), longint'($urandom_range(0, 65535)) - 32768,
                     lows, highs, "random", err);
        end
        for (int k = 0; k < 16; k++) begin lows[k] = rand_sample(); highs[k] = rand_sample(); end
        run_pair(9, 1, 1'b0, 0, lows, highs, "sel_clamp", err);
    endtask

    task automatic test_overrun();
        int lows[16], highs[16];
        int ov0, st0;
        longint err;
        for (int k = 0; k < 16; k++) begin lows[k] = rand_sample(); highs[k] = rand_sample(); end
        restart();
        ov0 = ov_cnt;
        st0 = step_cnt;
        i_avg_sel = 5'd2;
        drive_half(1'b0, 2, 4, lows);
        observe_low(floor_div(longint'(lows[0] + lows[1] + lows[2] + lows[3]), 4), "overrun_low");
        drive_half(1'b1, 2, 2, highs);
        @(negedge i_clk);
        drive_half(1'b1, 2, 4, highs);
        observe_sync(1'b0, 0, 0, "overrun_discard");
        tests_run++;
        if (ov_cnt - ov0 != 1 || step_cnt != st0) begin
            tests_failed++;
            $display("FAIL overrun_pulses: overrun %0d step %0d expected 1 0", ov_cnt - ov0, step_cnt - st0);
        end
        run_pair(2, 2, 1'b0, 0, lows, highs, "overrun_recover", err);
    endtask

    task automatic test_ordering();
        int highs[16];
        int st0;
        for (int k = 0; k < 16; k++) highs[k] = rand_sample();
        restart();
        st0 = step_cnt;
        i_avg_sel = 5'd1;
        drive_half(1'b1, 1, 2, highs);
        observe_sync(1'b0, 0, 0, "order_first_high");
        drive_half(1'b1, 1, 2, highs);
        observe_sync(1'b0, 0, 0, "order_second_high");
        tests_run++;
        if (step_cnt != st0) begin
            tests_failed++;
            $display("FAIL order_no_step: got %0d expected 0", step_cnt - st0);
        end
    endtask

    task automatic test_watchdog();
        int lows[16];
        int hits, first_pos, second_pos;
        for (int k = 0; k < 16; k++) lows[k] = rand_sample();
        i_timeout_cnt = 32'd20;
        restart();
        hits = 0; first_pos = 0; second_pos = 0;
        for (int i = 2; i <= 45; i++) begin
            @(negedge i_clk);
            if (o_timeout === 1'b1) begin
                hits++;
                if (hits == 1) first_pos = i - 1;
                if (hits == 2) second_pos = i - 1;
            end
        end
        tests_run++;
        if (hits != 2 || first_pos != 20 || second_pos != 40) begin
            tests_failed++;
            $display("FAIL watchdog_timing: hits %0d at %0d,%0d expected 2 at 20,40", hits, first_pos, second_pos);
        end
        i_avg_sel = 5'd1;
        drive_half(1'b0, 0, 2, lows);
        observe_low(floor_div(longint'(lows[0] + lows[1]), 2), "watchdog_low");
        repeat (25) @(negedge i_clk);
        drive_half(1'b1, 0, 2, lows);
        observe_sync(1'b0, 0, 0, "watchdog_clears_low");
        i_timeout_cnt = 32'd0;
    endtask

    task automatic test_reset_mid();
        int lows[16], highs[16];
        longint err;
        for (int k = 0; k < 16; k++) begin lows[k] = -100; highs[k] = 300; end
        restart();
        run_pair(2, 1, 1'b0, 0, lows, highs, "pre_reset", err);
        drive_half(1'b0, 1, 4, lows);
        observe_low(-100, "pre_reset_low");
        drive_half(1'b1, 1, 2, highs);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        tests_run++;
        if (o_cstate !== 4'd0 || o_err !== '0 || o_low_avg !== '0 || o_high_avg !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: state %0d err %0d low %0d high %0d expected 0", o_cstate, o_err, o_low_avg, o_high_avg);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
        drive_half(1'b1, 1, 4, highs);
        observe_sync(1'b0, 0, 0, "after_reset_high");
    endtask

    task automatic test_enable_drop();
        int lows[16], highs[16];
        longint err;
        for (int k = 0; k < 16; k++) begin lows[k] = rand_sample(); highs[k] = rand_sample(); end
        restart();
        run_pair(1, 2, 1'b0, 1234, lows, highs, "pre_disable", err);
        i_status = 1'b0; i_trig = 1'b1; i_wait_cnt = 32'd4;
        @(negedge i_clk);
        i_trig = 1'b0;
        @(negedge i_clk);
        i_en = 1'b0;
        @(negedge i_clk);
        tests_run++;
        if (o_cstate !== 4'd0 || o_err !== ERR_W'(err)) begin
            tests_failed++;
            $display("FAIL disable_hold: state %0d err %0d expected 0 %0d", o_cstate, o_err, err);
        end
        i_en = 1'b1;
        @(negedge i_clk);
        drive_half(1'b1, 0, 2, highs);
        observe_sync(1'b0, 0, 0, "disable_clears_low");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_random();
        test_overrun();
        test_ordering();
        test_watchdog();
        test_reset_mid();
        test_enable_drop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
